// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: receive-side checker for the six traffic lamp drives.
// Decodes both directions and flags conflicts, invalid encodings, illegal
// sequences and short yellow phases. A fault is latched with its code and
// drives a fail-safe red flash until cleared under an all-red pattern.
// Optional macro LAMP_MONITOR_WATCHDOG_EN adds a per-direction stuck-state
// watchdog (fault code 5) using MAX_DWELL.
module traffic_lamp_monitor #(
    parameter int MIN_YELLOW = 4,
    parameter int FLASH_DIV  = 8,
    parameter int MAX_DWELL  = 1024,
    parameter int CNT_W      = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       MR,
    input  logic       MY,
    input  logic       MG,
    input  logic       SR,
    input  logic       SY,
    input  logic       SG,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic       flash_red,
    output logic [1:0] main_state,
    output logic [1:0] side_state
);

    typedef enum logic [1:0] {ST_INIT, ST_MONITOR, ST_FAULT} state_e;

    localparam logic [1:0] LAMP_R = 2'd0;
    localparam logic [1:0] LAMP_G = 2'd1;
    localparam logic [1:0] LAMP_Y = 2'd2;
    localparam logic [1:0] LAMP_X = 2'd3;

    localparam int FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FL_W-1:0]  FLASH_LAST = FL_W'(FLASH_DIV - 1);
    // Ceiling just past MAX_DWELL: enough to express "held too long" without wrapping.
    localparam logic [CNT_W-1:0] DWELL_CAP  = CNT_W'(MAX_DWELL + 1);

    function automatic logic [1:0] decode_lamps(input logic r, input logic y, input logic g);
        case ({r, y, g})
            3'b100:  return LAMP_R;
            3'b001:  return LAMP_G;
            3'b010:  return LAMP_Y;
            default: return LAMP_X;
        endcase
    endfunction

    // Holding a state is always fine; changes must follow R -> G -> Y -> R.
    function automatic logic step_legal(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == cur) ||
               (prev == LAMP_R && cur == LAMP_G) ||
               (prev == LAMP_G && cur == LAMP_Y) ||
               (prev == LAMP_Y && cur == LAMP_R);
    endfunction

    function automatic logic [CNT_W-1:0] dwell_next(input logic [CNT_W-1:0] cnt,
                                                    input logic restart,
                                                    input logic counted);
        if (!counted) return '0;
        if (restart) return CNT_W'(1);
        if (cnt < DWELL_CAP) return cnt + 1'b1;
        return cnt;
    endfunction

    state_e            state_q, state_d;
    logic              fault_q, fault_d;
    logic [2:0]        code_q, code_d;
    logic [7:0]        count_q, count_d;
    logic              flash_q, flash_d;
    logic [FL_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic [1:0]        main_state_q, main_state_d;
    logic [1:0]        side_state_q, side_state_d;
    logic [CNT_W-1:0]  main_dwell_q, main_dwell_d;
    logic [CNT_W-1:0]  side_dwell_q, side_dwell_d;

    logic [1:0] main_dec, side_dec;
    logic       main_counted, side_counted;
    logic       conflict_f, invalid_f, sequence_f, short_f, stuck_f;
    logic [2:0] det_code;
    logic       clear_ok;

    assign main_dec = decode_lamps(MR, MY, MG);
    assign side_dec = decode_lamps(SR, SY, SG);
    assign clear_ok = clear_fault & MR & SR & ~(MY | MG | SY | SG);

`ifdef LAMP_MONITOR_WATCHDOG_EN
    assign main_counted = 1'b1;
    assign side_counted = 1'b1;
    assign stuck_f = (main_dec == main_state_q && main_dwell_q >= CNT_W'(MAX_DWELL)) ||
                     (side_dec == side_state_q && side_dwell_q >= CNT_W'(MAX_DWELL));
`else
    assign main_counted = (main_dec == LAMP_Y);
    assign side_counted = (side_dec == LAMP_Y);
    assign stuck_f      = 1'b0;
`endif

    // Per-direction dwell counters restart on a state change and on the INIT capture.
    always_comb begin
        main_state_d = main_dec;
        side_state_d = side_dec;
        main_dwell_d = dwell_next(main_dwell_q, (state_q == ST_INIT) || (main_dec != main_state_q),
                                  main_counted);
        side_dwell_d = dwell_next(side_dwell_q, (state_q == ST_INIT) || (side_dec != side_state_q),
                                  side_counted);
    end

    // Fault detectors against the previous decode; lowest code wins.
    always_comb begin
        conflict_f = (main_dec == LAMP_G || main_dec == LAMP_Y) &&
                     (side_dec == LAMP_G || side_dec == LAMP_Y);
        invalid_f  = (main_dec == LAMP_X) || (side_dec == LAMP_X);
        sequence_f = !step_legal(main_state_q, main_dec) || !step_legal(side_state_q, side_dec);
        short_f    = (main_state_q == LAMP_Y && main_dec == LAMP_R &&
                      main_dwell_q < CNT_W'(MIN_YELLOW)) ||
                     (side_state_q == LAMP_Y && side_dec == LAMP_R &&
                      side_dwell_q < CNT_W'(MIN_YELLOW));
        det_code = 3'd0;
        if (conflict_f)      det_code = 3'd1;
        else if (invalid_f)  det_code = 3'd2;
        else if (sequence_f) det_code = 3'd3;
        else if (short_f)    det_code = 3'd4;
        else if (stuck_f)    det_code = 3'd5;
    end

    // Monitor FSM: next state, fault latching, counting and flash generation.
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        code_d      = code_q;
        count_d     = count_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (det_code != 3'd0) begin
                    fault_d     = 1'b1;
                    code_d      = det_code;
                    count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    flash_d     = 1'b1;
                    flash_cnt_d = '0;
                    state_d     = ST_FAULT;
                end
            end
            ST_FAULT: begin
                // The clearing edge is consumed by the clear and is not checked.
                if (clear_ok) begin
                    fault_d     = 1'b0;
                    code_d      = 3'd0;
                    flash_d     = 1'b0;
                    flash_cnt_d = '0;
                    state_d     = ST_INIT;
                end else begin
                    if (det_code != 3'd0)
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_d     = ~flash_q;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            fault_q      <= 1'b0;
            code_q       <= 3'd0;
            count_q      <= 8'd0;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            main_state_q <= LAMP_R;
            side_state_q <= LAMP_R;
            main_dwell_q <= '0;
            side_dwell_q <= '0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            count_q      <= count_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            main_state_q <= main_state_d;
            side_state_q <= side_state_d;
            main_dwell_q <= main_dwell_d;
            side_dwell_q <= side_dwell_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign fault_count = count_q;
    assign flash_red   = flash_q;
    assign main_state  = main_state_q;
    assign side_state  = side_state_q;

endmodule
